out_word_serializer: RTL and testbench
======================================

// Module: out_word_serializer
// PURPOSE
// - Output-side counterpart of the word-packing stimulus wrapper: snapshots the wide packed DUT output vector and streams it back as 32-bit words.
// - Uses a valid/ready handshake, so the harness reads results one word at a time instead of over N parallel ports.
// - Sits between the DUT output bus and the harness readback channel; one snapshot yields one burst of NUM_WORDS words.
// PARAMETERS
// - NUM_WORDS  3   words per snapshot; packed vector width is NUM_WORDS*WORD_W (>=1)
// - WORD_W     32  bits per streamed word
// PORTS
// - clk      in   1                 single clock; all state changes on rising edge
// - rst_n    in   1                 asynchronous, active-low reset
// - snap_i   in   1                 snapshot request, single-cycle qualifier
// - data_i   in   NUM_WORDS*WORD_W  packed DUT output; word k = data_i[k*WORD_W +: WORD_W]
// - busy_o   out  1                 snapshot held / burst in progress
// - valid_o  out  1                 word_o is valid
// - ready_i  in   1                 consumer accepts word_o this cycle
// - word_o   out  WORD_W            current word
// - idx_o    out  $clog2(NUM_WORDS+1)  index of current word (checksum word = NUM_WORDS)
// - last_o   out  1                 current word is the final word of the burst
// - ovr_o    out  1                 sticky: snap_i arrived while busy and was dropped
// BEHAVIOUR
// - Reset (async assert, sync-release use): state=IDLE, all outputs 0, snapshot register 0.
// - States: IDLE -> STREAM [-> CSUM] -> IDLE.
// - IDLE: snap_i=1 captures data_i into the shadow register at the edge; next cycle STREAM, valid_o=1, idx_o=0.
// - Latency: snap_i to first valid word = 1 cycle.
// - STREAM: word_o = shadow word idx_o. On handshake (valid_o&ready_i), idx_o increments.
// - Output stability: while valid_o&!ready_i, word_o, idx_o and last_o hold stable; valid_o never drops without a handshake.
// - last_o=1 on word NUM_WORDS-1, or on the checksum word when CHECKSUM_EN is defined.
// - Final handshake: if snap_i=1 in the same cycle, recapture data_i and restart at idx 0 with no bubble (valid_o stays 1).
// - Final handshake without snap_i: return to IDLE; valid_o=0 and busy_o=0 the next cycle.
// - busy_o=1 in STREAM/CSUM; snap_i while busy (other than on the final-handshake cycle) is dropped and sets ovr_o.
// - ovr_o clears only on reset.
// - data_i changing after capture has no effect on the burst in flight.
// - NUM_WORDS=1: a single word with last_o=1.
// - Async reset mid-burst aborts immediately; the partial burst is discarded, no resume.
// CONFIGURATION
// - CHECKSUM_EN defined:
//   - After word NUM_WORDS-1, state CSUM emits one extra word = XOR of all NUM_WORDS shadow words, with idx_o=NUM_WORDS.
//   - last_o moves to the checksum word; burst length is NUM_WORDS+1.
// - CHECKSUM_EN undefined: CSUM state and XOR logic absent; burst length is NUM_WORDS.
// TESTING
// - Reset: rst_n=0 mid-burst (after 1 word) -> next cycle valid_o=0, busy_o=0, ovr_o=0, idx_o=0.
// - Basic burst, ready_i=1:
//   - Stimulus: snap_i with data_i={32'h3333_3333,32'h2222_2222,32'h1111_1111}.
//   - Words 1111_1111, 2222_2222, 3333_3333 on 3 consecutive cycles starting 1 cycle after snap.
//   - last_o only on the 3rd word.
//   - With CHECKSUM_EN, a 4th word 0000_0000 carries last_o.
// - Backpressure: ready_i=0 for 5 cycles on word 1 -> word_o=2222_2222 and idx_o=1 held stable, valid_o stays 1.
// - Back-to-back: snap_i with data_i word0=AAAA_0000 asserted on the last handshake -> next cycle word_o=AAAA_0000, idx_o=0, no idle cycle.
// - Overrun:
//   - snap_i pulsed at idx 1 with different data_i -> ovr_o=1, burst continues with the original words.
//   - ovr_o stays 1 after the burst completes.
// - Data isolation: data_i changed every cycle during a burst -> streamed words equal the value at capture.

Source files
------------

// File: rtl/out_word_serializer.sv
// Snapshots a packed NUM_WORDS*WORD_W vector and streams it out as WORD_W words over valid/ready.
// Optional CHECKSUM_EN appends an XOR word of the snapshot as the final word of each burst.
module out_word_serializer #(
  parameter int unsigned NUM_WORDS = 3,
  parameter int unsigned WORD_W    = 32,
  localparam int unsigned IDX_W    = $clog2(NUM_WORDS + 1),
  localparam int unsigned DATA_W   = NUM_WORDS * WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              snap_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              busy_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [WORD_W-1:0] word_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              last_o,
  output logic              ovr_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
`ifdef CHECKSUM_EN
  localparam logic [1:0] ST_CSUM   = 2'd2;
  localparam logic [IDX_W-1:0] CSUM_IDX = IDX_W'(NUM_WORDS);
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic              ovr_q, ovr_d;

  logic              active;
  logic              on_last;
  logic              hs;
  logic              final_hs;
  logic [WORD_W-1:0] sel_word;

  assign active   = (state_q != ST_IDLE);
  assign hs       = active && ready_i;
  assign final_hs = hs && on_last;

  // Compare-based mux keeps the index width independent of the word count.
  always_comb begin
    sel_word = '0;
    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_word = shadow_q[k*WORD_W +: WORD_W];
      end
    end
  end

`ifdef CHECKSUM_EN
  logic [WORD_W-1:0] csum_word;

  always_comb begin
    csum_word = '0;
    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
      csum_word = csum_word ^ shadow_q[k*WORD_W +: WORD_W];
    end
  end

  assign on_last = (state_q == ST_CSUM);
`else
  assign on_last = (state_q == ST_STREAM) && (idx_q == LAST_IDX);
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    ovr_d    = ovr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (snap_i) begin
          shadow_d = data_i;
          idx_d    = '0;
          state_d  = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (hs && (idx_q != LAST_IDX)) begin
          idx_d = idx_q + IDX_W'(1);
        end
`ifdef CHECKSUM_EN
        else if (hs) begin
          idx_d   = CSUM_IDX;
          state_d = ST_CSUM;
        end
`endif
      end
`ifdef CHECKSUM_EN
      ST_CSUM: begin
      end
`endif
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase

    // The last handshake either restarts on a fresh snapshot or drops back to idle.
    if (final_hs) begin
      idx_d = '0;
      if (snap_i) begin
        shadow_d = data_i;
        state_d  = ST_STREAM;
      end else begin
        state_d  = ST_IDLE;
      end
    end

    if (active && snap_i && !final_hs) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    word_o = '0;
    if (state_q == ST_STREAM) begin
      word_o = sel_word;
    end
`ifdef CHECKSUM_EN
    else if (state_q == ST_CSUM) begin
      word_o = csum_word;
    end
`endif
  end

  assign busy_o  = active;
  assign valid_o = active;
  assign idx_o   = idx_q;
  assign last_o  = on_last;
  assign ovr_o   = ovr_q;

endmodule

// File: tb/tb_out_word_serializer.sv
// Scoreboard bench for out_word_serializer: driver predicts bursts from a word-level model, monitor checks.
module tb_out_word_serializer;

  localparam int NW = 3;
  localparam int WW = 32;
  localparam int IW = $clog2(NW + 1);
  localparam int DW = NW * WW;
`ifdef CHECKSUM_EN
  localparam int BL = NW + 1;
`else
  localparam int BL = NW;
`endif

  typedef struct {
    logic [WW-1:0] word;
    int            idx;
    bit            last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          snap_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          busy_o;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [WW-1:0] word_o;
  logic [IW-1:0] idx_o;
  logic          last_o;
  logic          ovr_o;

  out_word_serializer #(.NUM_WORDS(NW), .WORD_W(WW)) dut (
    .clk(clk), .rst_n(rst_n), .snap_i(snap_i), .data_i(data_i),
    .busy_o(busy_o), .valid_o(valid_o), .ready_i(ready_i),
    .word_o(word_o), .idx_o(idx_o), .last_o(last_o), .ovr_o(ovr_o)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   pending = 0;
  bit   ovr_m = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int k = 0; k < NW; k++) d[k*WW +: WW] = $urandom;
    return d;
  endfunction

  task automatic push_burst(input logic [DW-1:0] d);
    logic [WW-1:0] x;
    exp_t e;
    x = '0;
    for (int k = 0; k < NW; k++) begin
      e.word = d[k*WW +: WW];
      e.idx  = k;
      e.last = (k == NW - 1) && (BL == NW);
      x      = x ^ e.word;
      sb.push_back(e);
    end
    if (BL > NW) begin
      e.word = x;
      e.idx  = NW;
      e.last = 1'b1;
      sb.push_back(e);
    end
  endtask

  // One clock: drive inputs, then apply the word-level model at the edge.
  task automatic step(input bit snap, input logic [DW-1:0] d, input bit rdy);
    bit acc;
    snap_i  = snap;
    data_i  = d;
    ready_i = rdy;
    @(posedge clk);
    acc = snap && (pending == 0 || (pending == 1 && rdy));
    if (snap && !acc) ovr_m = 1'b1;
    if (pending > 0 && rdy) pending--;
    if (acc) begin
      push_burst(d);
      pending += BL;
    end
    #1;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, rand_data(), 1'b1);
  endtask

  task automatic do_reset(input string tag);
    snap_i  = 1'b0;
    ready_i = 1'b0;
    rst_n   = 1'b0;
    sb.delete();
    pending = 0;
    ovr_m   = 1'b0;
    @(negedge clk);
    chk({tag, "_valid"}, 64'(valid_o), 64'd0);
    chk({tag, "_busy"},  64'(busy_o),  64'd0);
    chk({tag, "_ovr"},   64'(ovr_o),   64'd0);
    chk({tag, "_idx"},   64'(idx_o),   64'd0);
    chk({tag, "_last"},  64'(last_o),  64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every handshake and checks hold behaviour under backpressure.
  initial begin
    bit            hold = 1'b0;
    logic [WW-1:0] p_word;
    logic [IW-1:0] p_idx;
    logic          p_last;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        chk("valid", 64'(valid_o), 64'(pending > 0));
        chk("busy",  64'(busy_o),  64'(pending > 0));
        chk("ovr",   64'(ovr_o),   64'(ovr_m));
        if (hold) begin
          chk("hold_valid", 64'(valid_o), 64'd1);
          chk("hold_word",  64'(word_o),  64'(p_word));
          chk("hold_idx",   64'(idx_o),   64'(p_idx));
          chk("hold_last",  64'(last_o),  64'(p_last));
        end
        if (valid_o === 1'b1 && ready_i === 1'b1) begin
          if (sb.size() == 0) begin
            chk("unexpected_word", 64'(word_o), 64'hDEAD_0000_0000_0000);
          end else begin
            e = sb.pop_front();
            chk("word", 64'(word_o), 64'(e.word));
            chk("idx",  64'(idx_o),  64'(e.idx));
            chk("last", 64'(last_o), 64'(e.last));
          end
        end
        hold   = (valid_o === 1'b1) && (ready_i === 1'b0);
        p_word = word_o;
        p_idx  = idx_o;
        p_last = last_o;
      end
    end
  end

  initial begin
    logic [DW-1:0] d_basic;
    logic [DW-1:0] d_next;
    d_basic = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

    repeat (3) @(posedge clk);
    do_reset("reset");
    chk("reset_word", 64'(word_o), 64'd0);

    // Basic burst with data_i scrambled every cycle after capture.
    step(1'b1, d_basic, 1'b1);
    chk("first_latency_valid", 64'(valid_o), 64'd1);
    chk("first_word", 64'(word_o), 64'h1111_1111);
    idle_steps(BL + 2);

    // Backpressure on word 1.
    step(1'b1, d_basic, 1'b1);
    step(1'b0, rand_data(), 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, rand_data(), 1'b0);
    chk("bp_word",  64'(word_o),  64'h2222_2222);
    chk("bp_idx",   64'(idx_o),   64'd1);
    chk("bp_valid", 64'(valid_o), 64'd1);
    idle_steps(BL + 2);

    // Back-to-back: new snapshot on the final handshake.
    d_next = rand_data();
    d_next[WW-1:0] = 32'hAAAA_0000;
    step(1'b1, d_basic, 1'b1);
    for (int i = 1; i < BL; i++) step(1'b0, rand_data(), 1'b1);
    step(1'b1, d_next, 1'b1);
    chk("b2b_word",  64'(word_o),  64'hAAAA_0000);
    chk("b2b_idx",   64'(idx_o),   64'd0);
    chk("b2b_valid", 64'(valid_o), 64'd1);
    idle_steps(BL + 2);

    // Overrun at idx 1 with different data.
    step(1'b1, d_basic, 1'b1);
    step(1'b0, rand_data(), 1'b1);
    step(1'b1, rand_data(), 1'b0);
    chk("ovr_set", 64'(ovr_o), 64'd1);
    idle_steps(BL + 2);
    chk("ovr_sticky", 64'(ovr_o), 64'd1);

    // Reset after one word of a burst.
    step(1'b1, d_basic, 1'b1);
    step(1'b0, rand_data(), 1'b1);
    do_reset("midrst");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) == 0), rand_data(), ($urandom_range(0, 3) != 0));
    end
    idle_steps(BL + 4);
    chk("drain_sb", 64'(sb.size()), 64'd0);
    chk("drain_pending", 64'(pending), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
